// File: rtl/result_checker_pkg.sv
// Shared parameters, state encoding and helpers for the filter-output result checker.
package result_checker_pkg;
    localparam int DATA_W  = 14;
    localparam int CNT_W   = 16;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 1024;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/result_checker_if.sv
// Sample/expected streams in, verdict and statistics out.
interface result_checker_if #(
    parameter int DATA_W = result_checker_pkg::DATA_W,
    parameter int CNT_W  = result_checker_pkg::CNT_W
);
    logic              VIN;
    logic [DATA_W-1:0] DIN;
    logic              VEXP;
    logic [DATA_W-1:0] DEXP;
    logic [CNT_W-1:0]  NSAMP;
    logic              MISMATCH;
    logic [CNT_W-1:0]  SAMP_CNT;
    logic [CNT_W-1:0]  ERR_CNT;
    logic              OVF;
    logic              UNF;
    logic              TMO;
    logic              DONE;
    logic              PASS;
    logic              END_SIM;

    modport master (
        output VIN, DIN, VEXP, DEXP, NSAMP,
        input  MISMATCH, SAMP_CNT, ERR_CNT, OVF, UNF, TMO, DONE, PASS, END_SIM
    );
    modport slave (
        input  VIN, DIN, VEXP, DEXP, NSAMP,
        output MISMATCH, SAMP_CNT, ERR_CNT, OVF, UNF, TMO, DONE, PASS, END_SIM
    );
endinterface

// File: rtl/exp_fifo.sv
// Expected-sample FIFO; head is visible combinationally so a pop can compare in the same cycle.
module exp_fifo #(
    parameter int DATA_W = 14,
    parameter int DEPTH  = 8
) (
    input  logic              gclk,
    input  logic              grst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;

    // Extra pointer MSB separates full from empty when the indices coincide.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge gclk) begin
        if (!grst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge gclk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/result_checker.sv
// Compares a filter output stream against queued expected samples and produces a pass/fail verdict.
module result_checker
    import result_checker_pkg::*;
#(
    parameter int DATA_W  = result_checker_pkg::DATA_W,
    parameter int DEPTH   = result_checker_pkg::DEPTH,
    parameter int TIMEOUT = result_checker_pkg::TIMEOUT
) (
    input logic           CLK,
    input logic           RST_n,
    result_checker_if.slave bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  nsamp_q;
    logic [CNT_W-1:0]  samp_q, samp_d, err_q, err_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              ovf_q, ovf_d, unf_q, unf_d, tmo_q, tmo_d;
    logic              mis_q, mis_d, done_q, pass_q;
    logic              push, pop, full, empty;
    logic [DATA_W-1:0] head;

    exp_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .gclk  (CLK),
        .grst_n(RST_n),
        .push  (push),
        .pop   (pop),
        .din   (bus.DEXP),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d = state_q;
        samp_d  = samp_q;
        err_d   = err_q;
        wd_d    = wd_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        tmo_d   = tmo_q;
        mis_d   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;

        unique case (state_q)
            IDLE: begin
                wd_d    = '0;
                state_d = (bus.NSAMP == '0) ? DONE : RUN;
            end
            RUN: begin
                if (bus.VIN) begin
                    wd_d   = '0;
                    samp_d = sat_inc(samp_q);
                    // An empty FIFO counts as a failed compare; a same-cycle push is not bypassed.
                    if (empty) begin
                        unf_d = 1'b1;
                        err_d = sat_inc(err_q);
                        mis_d = 1'b1;
                    end else begin
                        pop = 1'b1;
                        if (head != bus.DIN) begin
                            err_d = sat_inc(err_q);
                            mis_d = 1'b1;
                        end
                    end
                    if (samp_d == nsamp_q) state_d = DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                    if (wd_d == TIMEOUT[WD_W-1:0]) begin
                        tmo_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            default: ;
        endcase

        if (state_q != DONE && bus.VEXP) begin
            if (!full || pop) push  = 1'b1;
            else              ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_q <= IDLE;
            nsamp_q <= '0;
            samp_q  <= '0;
            err_q   <= '0;
            wd_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            tmo_q   <= 1'b0;
            mis_q   <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            if (state_q == IDLE) nsamp_q <= bus.NSAMP;
            state_q <= state_d;
            samp_q  <= samp_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            tmo_q   <= tmo_d;
            mis_q   <= mis_d;
            done_q  <= (state_d == DONE);
            pass_q  <= (state_d == DONE) && (err_d == '0) && !ovf_d && !unf_d && !tmo_d;
        end
    end

    assign bus.MISMATCH = mis_q;
    assign bus.SAMP_CNT = samp_q;
    assign bus.ERR_CNT  = err_q;
    assign bus.OVF      = ovf_q;
    assign bus.UNF      = unf_q;
    assign bus.TMO      = tmo_q;
    assign bus.DONE     = done_q;
    assign bus.PASS     = pass_q;
    assign bus.END_SIM  = done_q;
endmodule

// File: tb/tb_result_checker.sv
// Directed, table-driven bench for result_checker; one row = inputs before an edge, outputs after it.
module tb_result_checker;
    localparam int DW = 14;
    localparam int TO = 1024;

    typedef struct {
        logic        rst;
        logic [15:0] nsamp;
        logic        vin;
        logic [DW-1:0] din;
        logic        vexp;
        logic [DW-1:0] dexp;
        logic        mis;
        logic [15:0] samp;
        logic [15:0] err;
        logic        ovf, unf, tmo, done, pass;
    } vec_t;

    logic CLK = 1'b0;
    logic RST_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl[$];

    result_checker_if #(.DATA_W(DW)) bus();

    result_checker #(.DATA_W(DW), .DEPTH(8), .TIMEOUT(TO)) dut (
        .CLK  (CLK),
        .RST_n(RST_n),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mk(input logic rst, input int ns, input logic vin, input int din,
                                input logic vexp, input int dexp, input logic mis, input int samp,
                                input int err, input logic ovf, input logic unf, input logic tmo,
                                input logic done, input logic pass);
        vec_t v;
        v.rst = rst; v.nsamp = 16'(ns); v.vin = vin; v.din = DW'(din);
        v.vexp = vexp; v.dexp = DW'(dexp); v.mis = mis; v.samp = 16'(samp); v.err = 16'(err);
        v.ovf = ovf; v.unf = unf; v.tmo = tmo; v.done = done; v.pass = pass;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag, input int idx);
        RST_n    = ~v.rst;
        bus.NSAMP = v.nsamp;
        bus.VIN  = v.vin;
        bus.DIN  = v.din;
        bus.VEXP = v.vexp;
        bus.DEXP = v.dexp;
        @(posedge CLK);
        #1;
        n_vec++;
        if ({bus.MISMATCH, bus.SAMP_CNT, bus.ERR_CNT, bus.OVF, bus.UNF, bus.TMO, bus.DONE, bus.PASS, bus.END_SIM}
            !== {v.mis, v.samp, v.err, v.ovf, v.unf, v.tmo, v.done, v.pass, v.done}) begin
            n_err++;
            $display("FAIL %s[%0d]: got mis=%b samp=%0d err=%0d ovf=%b unf=%b tmo=%b done=%b pass=%b end=%b, want mis=%b samp=%0d err=%0d ovf=%b unf=%b tmo=%b done=%b pass=%b",
                     tag, idx, bus.MISMATCH, bus.SAMP_CNT, bus.ERR_CNT, bus.OVF, bus.UNF, bus.TMO,
                     bus.DONE, bus.PASS, bus.END_SIM, v.mis, v.samp, v.err, v.ovf, v.unf, v.tmo,
                     v.done, v.pass);
        end
    endtask

    task automatic run_table(input string tag);
        foreach (tbl[i]) apply(tbl[i], tag, i);
        tbl.delete();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Four expected samples, matching outputs after five cycles; optional corrupt third sample.
    task automatic build_basic(input bit bad);
        tbl.push_back(mk(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 4; i++) tbl.push_back(mk(0, 4, 0, 0, 1, i, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4, 1, 2, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4, 1, bad ? 'h3FFF : 3, 0, 0, bad, 3, bad, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4, 1, 4, 0, 0, 0, 4, bad, 0, 0, 0, 1, !bad));
        tbl.push_back(mk(0, 4, 1, 9, 1, 9, 0, 4, bad, 0, 0, 0, 1, !bad));
    endtask

    initial begin
        bus.VIN = 1'b0; bus.DIN = '0; bus.VEXP = 1'b0; bus.DEXP = '0; bus.NSAMP = '0;

        build_basic(1'b0);
        run_table("clean");
        build_basic(1'b1);
        run_table("mismatch");

        // Underflow on the first RUN cycle, with a simultaneous push that must not bypass.
        tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 3, 1, 5, 1, 5, 1, 1, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 3, 1, 5, 0, 0, 0, 2, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 3, 1, 6, 0, 0, 1, 3, 2, 0, 1, 0, 1, 0));
        run_table("underflow");

        // NSAMP of zero finishes straight from IDLE.
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 3, 1, 3, 0, 0, 0, 0, 0, 0, 1, 1));
        run_table("nsamp0");

        // Reset mid-RUN after two samples, then a fresh NSAMP of one.
        tbl.push_back(mk(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4, 1, 2, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 8, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1));
        run_table("midreset");

        // Overflow: nine pushes into an eight-deep FIFO, the ninth is dropped.
        apply(mk(1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ovf", 0);
        for (int i = 0; i < 9; i++)
            apply(mk(0, 10, 0, 0, 1, i + 1, 0, 0, 0, i == 8, 0, 0, 0, 0), "ovf_push", i);
        for (int i = 0; i < 8; i++)
            apply(mk(0, 10, 1, i + 1, 0, 0, 0, i + 1, 0, 1, 0, 0, 0, 0), "ovf_pop", i);
        apply(mk(0, 10, 1, 9, 0, 0, 1, 9, 1, 1, 1, 0, 0, 0), "ovf_drop", 0);
        apply(mk(0, 10, 1, 9, 0, 0, 1, 10, 2, 1, 1, 0, 1, 0), "ovf_done", 0);

        // Watchdog: three samples then silence until timeout.
        apply(mk(1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "tmo", 0);
        for (int i = 0; i < 3; i++)
            apply(mk(0, 10, 0, 0, 1, 20 + i, 0, 0, 0, 0, 0, 0, 0, 0), "tmo_push", i);
        for (int i = 0; i < 3; i++)
            apply(mk(0, 10, 1, 20 + i, 0, 0, 0, i + 1, 0, 0, 0, 0, 0, 0), "tmo_pop", i);
        begin
            int k = 0;
            bus.VIN = 1'b0;
            while (!bus.DONE && k < 2 * TO) begin
                @(posedge CLK);
                #1;
                k++;
            end
            chk("tmo_cycles", k, TO);
            chk("tmo_flag", int'(bus.TMO), 1);
            chk("tmo_pass", int'(bus.PASS), 0);
            chk("tmo_samp", int'(bus.SAMP_CNT), 3);
            chk("tmo_end_sim", int'(bus.END_SIM), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
